// File: rtl/e_calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | e_calc_pkg : shared types for the e calculator and digit serializer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package e_calc_pkg;

  localparam int WORD_W  = 16;
  localparam int DIGIT_W = 4;
  localparam int E_WORDS = 32;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [DIGIT_W-1:0] digit_t;
  typedef word_t              e_words_t [0:E_WORDS-1];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INT  = 2'd1,
    MUL  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Integer part saturates at 9 so it always fits one BCD digit.
  function automatic digit_t sat_digit(input word_t w);
    return (w > word_t'(9)) ? digit_t'(9) : w[DIGIT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/e_mul10_word.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | e_mul10_word : one 16-bit limb of a multi-word multiply-by-10        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module e_mul10_word
  import e_calc_pkg::*;
(
  input  logic [WORD_W-1:0]  word,
  input  logic [DIGIT_W-1:0] cin,
  output logic [WORD_W-1:0]  prod,
  output logic [DIGIT_W-1:0] cout
);

  logic [WORD_W+DIGIT_W-1:0] ext;
  logic [WORD_W+DIGIT_W-1:0] sum;

  // 10*w = 8*w + 2*w; the 20-bit sum cannot overflow (65535*10+9 < 2^20)
  assign ext  = {{DIGIT_W{1'b0}}, word};
  assign sum  = (ext << 3) + (ext << 1) + {{WORD_W{1'b0}}, cin};
  assign prod = sum[WORD_W-1:0];
  assign cout = sum[WORD_W+DIGIT_W-1:WORD_W];

endmodule
`default_nettype wire

// File: rtl/e_dec_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | e_dec_serializer : streams a fixed-point value as BCD digits         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module e_dec_serializer
  import e_calc_pkg::*;
#(
  parameter int WORDS  = 32,
  parameter int DIGITS = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WORD_W-1:0]  in_data [0:WORDS-1],
  output logic               busy,
  output logic               dig_valid,
  input  logic               dig_ready,
  output logic [DIGIT_W-1:0] dig_data,
  output logic               dig_int,
  output logic               dig_last,
  output logic               int_ovf,
  output logic               done
);

  localparam int IDX_W = (WORDS > 2) ? $clog2(WORDS) : 1;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state, state_nx;
  word_t              frac [1:WORDS-1];
  logic [IDX_W-1:0]   idx;
  digit_t             carry;
  digit_t             digit;
  logic [CNT_W-1:0]   count;
  word_t              mul_word;
  digit_t             mul_carry;
  logic               accept;
  logic               hs;
  logic               mul_end;
  logic               last;

  e_mul10_word u_mul10 (
    .word (frac[idx]),
    .cin  (carry),
    .prod (mul_word),
    .cout (mul_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    hs        = 1'b0;
    mul_end   = 1'b0;
    last      = (count == CNT_LAST);
    busy      = (state != IDLE);
    dig_valid = (state == INT) || (state == OUT);
    dig_int   = (state == INT);
    dig_last  = (state == OUT) && last;
    dig_data  = digit;
    case (state)
      IDLE: if (load) begin
        accept   = 1'b1;
        state_nx = INT;
      end
      INT: if (dig_ready) begin
        hs       = 1'b1;
        state_nx = MUL;
      end
      MUL: if (idx == IDX_ONE) begin
        mul_end  = 1'b1;
        state_nx = OUT;
      end
      OUT: if (dig_ready) begin
        hs       = 1'b1;
        state_nx = last ? IDLE : MUL;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < WORDS; i++) frac[i] <= '0;
      idx     <= '0;
      carry   <= '0;
      digit   <= '0;
      count   <= '0;
      int_ovf <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        for (int i = 1; i < WORDS; i++) frac[i] <= in_data[i];
        digit   <= sat_digit(in_data[0]);
        int_ovf <= (in_data[0] > word_t'(9));
        count   <= '0;
      end
      if (hs) begin
        idx   <= IDX_TOP;
        carry <= '0;
      end
      if (hs && (state == OUT)) begin
        count <= count + CNT_ONE;
        if (last) done <= 1'b1;
      end
      // Least significant limb first so the carry ripples upward; the carry
      // out of the top limb is the next decimal digit.
      if (state == MUL) begin
        frac[idx] <= mul_word;
        carry     <= mul_carry;
        idx       <= idx - IDX_ONE;
        if (mul_end) digit <= mul_carry;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_e_dec_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_e_dec_serializer : directed bench for the BCD digit serializer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_e_dec_serializer;
  import e_calc_pkg::*;

  localparam int AW = 2;
  localparam int AD = 4;
  localparam int BW = 32;
  localparam int BD = 100;

  // First 100 decimals of e, independent of any bench arithmetic.
  string ED = {"7182818284590452353602874713526624977572",
               "4709369995957496696762772407663035354759",
               "45713821785251664274"};

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  int     cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;

  logic   a_load = 1'b0, a_ready = 1'b1;
  word_t  a_in [0:AW-1];
  logic   a_busy, a_valid, a_int, a_last, a_ovf, a_done;
  digit_t a_data;

  logic   b_load = 1'b0, b_ready = 1'b1;
  word_t  b_in [0:BW-1];
  logic   b_busy, b_valid, b_int, b_last, b_ovf, b_done;
  digit_t b_data;

  int unsigned     term [0:BW-1];
  int unsigned     esum [0:BW-1];
  longint unsigned cur, rem;
  bit              nz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  e_dec_serializer #(.WORDS(AW), .DIGITS(AD)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .load(a_load), .in_data(a_in),
    .busy(a_busy), .dig_valid(a_valid), .dig_ready(a_ready), .dig_data(a_data),
    .dig_int(a_int), .dig_last(a_last), .int_ovf(a_ovf), .done(a_done)
  );

  e_dec_serializer #(.WORDS(BW), .DIGITS(BD)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .load(b_load), .in_data(b_in),
    .busy(b_busy), .dig_valid(b_valid), .dig_ready(b_ready), .dig_data(b_data),
    .dig_int(b_int), .dig_last(b_last), .int_ovf(b_ovf), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic a_wait(input string tag);
    int t = 0;
    while (!a_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " valid"}, 32'(a_valid), 1);
  endtask

  task automatic b_wait(input string tag);
    int t = 0;
    while (!b_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " valid"}, 32'(b_valid), 1);
  endtask

  // exp holds five BCD nibbles: integer digit first, then four fraction digits.
  task automatic a_stream(input string tag, input word_t w0, input word_t w1,
                          input logic [19:0] exp, input logic exp_ovf,
                          input int stall_idx, input bit junk);
    int     hs_cyc;
    digit_t expd;
    @(negedge clk);
    chk({tag, " done_idle"}, 32'(a_done), 0);
    a_in[0] = w0;
    a_in[1] = w1;
    a_load  = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    chk({tag, " latency"}, 32'(a_valid), 1);
    chk({tag, " busy"}, 32'(a_busy), 1);
    hs_cyc = -1;
    for (int k = 0; k < 5; k++) begin
      a_wait(tag);
      if (hs_cyc >= 0) chk({tag, " gap"}, 32'(cyc - hs_cyc), 2);
      expd = exp[19-4*k -: 4];
      chk($sformatf("%s d%0d", tag, k), 32'(a_data), 32'(expd));
      chk($sformatf("%s int%0d", tag, k), 32'(a_int), 32'(k == 0));
      chk($sformatf("%s last%0d", tag, k), 32'(a_last), 32'(k == 4));
      chk({tag, " ovf"}, 32'(a_ovf), 32'(exp_ovf));
      chk({tag, " early_done"}, 32'(a_done), 0);
      if (k == stall_idx) begin
        a_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk({tag, " stall_valid"}, 32'(a_valid), 1);
          chk({tag, " stall_data"}, 32'(a_data), 32'(expd));
        end
        a_ready = 1'b1;
      end
      if (junk && (k == 2 || k == 4)) a_load = 1'b1;
      hs_cyc = cyc;
      @(negedge clk);
      a_load = 1'b0;
    end
    chk({tag, " done"}, 32'(a_done), 1);
    chk({tag, " busy_end"}, 32'(a_busy), 0);
    chk({tag, " valid_end"}, 32'(a_valid), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    a_in[0] = '0;
    a_in[1] = '0;
    for (int i = 0; i < BW; i++) b_in[i] = '0;

    // e = sum 1/k!, built in 16-bit limbs; limb 0 is the integer part
    for (int i = 0; i < BW; i++) begin
      term[i] = 0;
      esum[i] = 0;
    end
    term[0] = 1;
    esum[0] = 1;
    for (int k = 1; k < 200; k++) begin
      rem = 0;
      nz  = 1'b0;
      for (int i = 0; i < BW; i++) begin
        cur     = (rem << 16) | 64'(term[i]);
        term[i] = 32'(cur / 64'(k));
        rem     = cur % 64'(k);
        if (term[i] != 0) nz = 1'b1;
      end
      if (!nz) break;
      cur = 0;
      for (int i = BW - 1; i >= 0; i--) begin
        cur     = 64'(esum[i]) + 64'(term[i]) + cur;
        esum[i] = 32'(cur & 64'hFFFF);
        cur     = cur >> 16;
      end
    end

    repeat (2) @(negedge clk);
    chk("rst a_valid", 32'(a_valid), 0);
    chk("rst a_busy", 32'(a_busy), 0);
    chk("rst a_data", 32'(a_data), 0);
    chk("rst a_flags", {28'd0, a_int, a_last, a_ovf, a_done}, 0);
    chk("rst b_valid", 32'(b_valid), 0);
    chk("rst b_busy", 32'(b_busy), 0);
    rst_n = 1'b1;

    a_stream("base",    16'd2,  16'hB7E1, 20'h27182, 1'b0, -1, 1'b0);
    a_stream("stall",   16'd2,  16'hB7E1, 20'h27182, 1'b0,  1, 1'b1);
    a_stream("half",    16'd1,  16'h8000, 20'h15000, 1'b0, -1, 1'b0);
    a_stream("quarter", 16'd0,  16'h4000, 20'h02500, 1'b0, -1, 1'b0);
    a_stream("ovf",     16'd12, 16'h0000, 20'h90000, 1'b1, -1, 1'b0);
    a_stream("reload",  16'd2,  16'hB7E1, 20'h27182, 1'b0, -1, 1'b0);

    // Full-width run against the known decimal expansion of e
    for (int i = 0; i < BW; i++) b_in[i] = word_t'(esum[i]);
    @(negedge clk);
    b_load = 1'b1;
    @(negedge clk);
    b_load = 1'b0;
    chk("e latency", 32'(b_valid), 1);
    for (int k = 0; k <= BD; k++) begin
      b_wait($sformatf("e%0d", k));
      chk($sformatf("e d%0d", k), 32'(b_data),
          (k == 0) ? 32'd2 : 32'(ED[k-1] - 8'd48));
      chk($sformatf("e int%0d", k), 32'(b_int), 32'(k == 0));
      chk($sformatf("e last%0d", k), 32'(b_last), 32'(k == BD));
      @(negedge clk);
    end
    chk("e done", 32'(b_done), 1);
    chk("e ovf", 32'(b_ovf), 0);

    // Mid-stream reset on both instances
    @(negedge clk);
    a_ready = 1'b0;
    a_in[0] = 16'd12;
    a_in[1] = 16'hB7E1;
    a_load  = 1'b1;
    b_load  = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    b_load = 1'b0;
    chk("mid a_data", 32'(a_data), 9);
    chk("mid a_ovf", 32'(a_ovf), 1);
    for (int k = 0; k < 10; k++) begin
      b_wait("mid_e");
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("mid b_busy", 32'(b_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst a_valid", 32'(a_valid), 0);
    chk("arst a_busy", 32'(a_busy), 0);
    chk("arst a_data", 32'(a_data), 0);
    chk("arst a_flags", {28'd0, a_int, a_last, a_ovf, a_done}, 0);
    chk("arst b_valid", 32'(b_valid), 0);
    chk("arst b_busy", 32'(b_busy), 0);
    chk("arst b_data", 32'(b_data), 0);
    @(negedge clk);
    rst_n   = 1'b1;
    a_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("arst no_done", {30'd0, a_done, b_done}, 0);
    end
    a_stream("post_rst", 16'd2, 16'hB7E1, 20'h27182, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
